// File: rtl/hex_display_sched.sv
// Shares one 4-digit hex display between four 16-bit sources: source 0 preempts,
// sources 1..3 rotate round-robin with a fixed dwell time per source.
module hex_display_sched #(
   parameter int unsigned DWELL = 50000000,
   parameter int unsigned CNT_W = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  i_req,
   input  logic [63:0] i_data,
   input  logic        i_freeze,
   output logic [15:0] o_data,
   output logic [1:0]  o_src,
   output logic        o_active,
   output logic        o_switch
);

   typedef enum logic [1:0] {IDLE, SHOW, PREEMPT} state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

   state_e           state_q, state_d;
   logic [1:0]       src_q, src_d;
   logic [1:0]       saved_q, saved_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      data_q, data_d;
   logic             active_q, active_d;
   logic             switch_q, switch_d;
   logic [1:0]       nxt;

   // First requester strictly after s in the ring 1->2->3->1, with s itself
   // checked last; 0 means nobody in the rotation is requesting.
   function automatic logic [1:0] rr_next(input logic [1:0] s, input logic [3:0] req);
      logic [1:0] c;
      rr_next = 2'd0;
      c = s;
      for (int k = 0; k < 3; k++) begin
         c = (c == 2'd3) ? 2'd1 : c + 2'd1;
         if (req[c] && rr_next == 2'd0) rr_next = c;
      end
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         src_q    <= 2'd0;
         saved_q  <= 2'd1;
         cnt_q    <= '0;
         data_q   <= 16'h0;
         active_q <= 1'b0;
         switch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         saved_q  <= saved_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         active_q <= active_d;
         switch_q <= switch_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      saved_d = saved_q;
      cnt_d   = cnt_q;
      nxt     = 2'd0;
      case (state_q)
         IDLE: begin
            nxt = rr_next(2'd3, i_req);
            if (i_req[0]) begin
               state_d = PREEMPT;
               src_d   = 2'd0;
               cnt_d   = '0;
            end else if (nxt != 2'd0) begin
               state_d = SHOW;
               src_d   = nxt;
               cnt_d   = '0;
            end
         end
         SHOW: begin
            if (i_req[0]) begin
               state_d = PREEMPT;
               saved_d = src_q;
               src_d   = 2'd0;
               cnt_d   = '0;
            end else if (!i_req[src_q]) begin
               nxt     = rr_next(src_q, i_req);
               state_d = (nxt != 2'd0) ? SHOW : IDLE;
               src_d   = nxt;
               cnt_d   = '0;
            end else if (!i_freeze) begin
               // On expiry the current source is still requesting, so rr_next
               // never returns 0 here and may return src_q itself.
               if (cnt_q == CNT_LAST) begin
                  src_d = rr_next(src_q, i_req);
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         PREEMPT: begin
            if (!i_req[0]) begin
               nxt     = i_req[saved_q] ? saved_q : rr_next(saved_q, i_req);
               state_d = (nxt != 2'd0) ? SHOW : IDLE;
               src_d   = nxt;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            src_d   = 2'd0;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      active_d = (state_d != IDLE);
      data_d   = active_d ? i_data[{src_d, 4'b0000} +: 16] : 16'h0;
      switch_d = (src_d != src_q) || (active_d != active_q);
   end

   assign o_data   = data_q;
   assign o_src    = src_q;
   assign o_active = active_q;
   assign o_switch = switch_q;

endmodule

// File: tb/tb_hex_display_sched.sv
// Bench for hex_display_sched: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the scheduling rules.
module tb_hex_display_sched;

   localparam int DWELL = 8;

   logic        clk;
   logic        rst_n;
   logic [3:0]  i_req;
   logic [63:0] i_data;
   logic        i_freeze;
   logic [15:0] o_data;
   logic [1:0]  o_src;
   logic        o_active;
   logic        o_switch;

   hex_display_sched #(.DWELL(DWELL), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_data(i_data), .i_freeze(i_freeze),
      .o_data(o_data), .o_src(o_src), .o_active(o_active), .o_switch(o_switch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;
   int cyc = 0;

   // model: what is on the display and for how long
   bit          m_act;
   int          m_src;
   int          m_saved;
   int          m_el;
   bit          m_sw;
   logic [15:0] m_data;

   int sw_src[$];
   int sw_cyc[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int after(input int s, input logic [3:0] r);
      for (int k = 1; k <= 3; k++) begin
         int c;
         c = (s - 1 + k) % 3 + 1;
         if (r[c]) return c;
      end
      return 0;
   endfunction

   task automatic model_step();
      bit pa;
      int ps;
      pa = m_act;
      ps = m_src;
      if (i_req[0]) begin
         if (m_act && m_src != 0) m_saved = m_src;
         m_act = 1'b1;
         m_src = 0;
         m_el  = 0;
      end else begin
         if (!m_act)               m_src = after(3, i_req);
         else if (m_src == 0)      m_src = i_req[m_saved] ? m_saved : after(m_saved, i_req);
         else if (!i_req[m_src])   m_src = after(m_src, i_req);
         else if (!i_freeze) begin
            m_el++;
            if (m_el == DWELL) begin
               m_el  = 0;
               m_src = after(m_src, i_req);
            end
         end
         if (m_src != ps || !pa) m_el = 0;
         m_act = (m_src != 0);
      end
      m_sw   = (pa != m_act) || (ps != m_src);
      m_data = m_act ? i_data[m_src*16 +: 16] : 16'h0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_src(input int s, input string nm);
      int n = 0;
      while (!(o_active && o_src == 2'(s)) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(nm, {31'd0, o_active && o_src == 2'(s)}, 32'd1);
   endtask

   task automatic chk_seq(input int base, input int s0, input int s1, input string nm);
      if (sw_src.size() < base + 2) begin
         chk({nm, "_cnt"}, sw_src.size() - base, 2);
      end else begin
         chk({nm, "_a"}, sw_src[base], s0);
         chk({nm, "_b"}, sw_src[base+1], s1);
         chk({nm, "_dwell"}, sw_cyc[base+1] - sw_cyc[base], DWELL);
      end
   endtask

   initial begin
      int base;
      rst_n = 1'b0; i_req = 4'h0; i_data = 64'h0; i_freeze = 1'b0;
      m_act = 0; m_src = 0; m_saved = 1; m_el = 0; m_sw = 0; m_data = 16'h0;

      fork
         forever @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               m_act = 0; m_src = 0; m_saved = 1; m_el = 0; m_sw = 0; m_data = 16'h0;
            end else begin
               cyc++;
               model_step();
            end
         end
         forever @(negedge clk) begin
            chk("active", {31'd0, o_active}, {31'd0, m_act});
            chk("switch", {31'd0, o_switch}, {31'd0, m_sw});
            chk("data", {16'd0, o_data}, {16'd0, m_data});
            if (m_act) chk("src", {30'd0, o_src}, m_src);
            if (o_switch && o_active) begin
               sw_src.push_back(int'(o_src));
               sw_cyc.push_back(cyc);
            end
         end
      join_none

      #12;
      chk("rst_active", {31'd0, o_active}, 32'd0);
      chk("rst_data", {16'd0, o_data}, 32'd0);
      #11 rst_n = 1'b1;

      // idle: no grant, no switch
      base = sw_src.size();
      step(10);
      chk("idle_switches", sw_src.size() - base, 0);
      chk("idle_data", {16'd0, o_data}, 32'd0);

      // plain rotation 1,2,3,1
      i_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
      base = sw_src.size();
      i_req = 4'b1110;
      step(40);
      chk_seq(base, 1, 2, "rot12");
      chk_seq(base + 2, 3, 1, "rot31");

      // single requester: one entry switch, then live data
      i_req = 4'b0000;
      step(3);
      base = sw_src.size();
      i_req = 4'b0100;
      step(40);
      chk("solo_switches", sw_src.size() - base, 1);
      chk("solo_src", {30'd0, o_src}, 32'd2);
      i_data[47:32] = 16'hBEEF;
      @(posedge clk); @(negedge clk);
      chk("solo_beef", {16'd0, o_data}, 32'h0000BEEF);

      // preempt during src 3 dwell, then fresh dwell on return
      i_req = 4'b1110;
      wait_src(3, "reach_src3");
      step(3);
      i_data[15:0] = 16'hDEAD;
      i_req = 4'b1111;
      step(5);
      chk("pre_src", {30'd0, o_src}, 32'd0);
      chk("pre_data", {16'd0, o_data}, 32'h0000DEAD);
      base = sw_src.size();
      i_req = 4'b1110;
      step(12);
      chk_seq(base, 3, 1, "pre_ret");

      // freeze holds, drop still switches, all-drop goes idle
      wait_src(1, "reach_src1");
      i_freeze = 1'b1;
      step(30);
      chk("frz_src", {30'd0, o_src}, 32'd1);
      i_req = 4'b1100;
      step(1);
      chk("frz_drop", {30'd0, o_src}, 32'd2);
      i_req = 4'b0000;
      step(1);
      chk("drop_active", {31'd0, o_active}, 32'd0);
      chk("drop_data", {16'd0, o_data}, 32'd0);
      i_freeze = 1'b0;

      // asynchronous reset mid-preempt
      i_req = 4'b0001;
      step(3);
      chk("pre2_src", {31'd0, o_active}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_active", {31'd0, o_active}, 32'd0);
      chk("arst_data", {16'd0, o_data}, 32'd0);
      chk("arst_src", {30'd0, o_src}, 32'd0);
      #10;
      i_req = 4'b0100;
      rst_n = 1'b1;
      step(2);
      chk("post_rst_src", {29'd0, o_active, o_src}, 32'b110);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if ($urandom_range(3) == 0) i_req[3:1] = 3'($urandom);
         if ($urandom_range(15) == 0) i_req[0] = ~i_req[0];
         i_freeze = ($urandom_range(3) == 0);
         if ($urandom_range(1) == 0) i_data = {$urandom, $urandom};
      end
      step(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/hex_display_sched.md
Name: hex_display_sched

Overview:
- Time-slicing scheduler that shares the single 4-digit hex display between four 16-bit requesters.
- Sources 1..3 rotate round-robin, each shown for a fixed dwell period.
- Source 0 is an urgent/alert channel: it preempts the rotation immediately and holds the display while requesting.
- Output o_data feeds the display driver's 16-bit data input directly; o_src/o_active drive status LEDs.

Parameters:
- DWELL, 50000000, cycles each rotating source stays on display (>=2).
- CNT_W, 26, dwell counter width; must satisfy 2^CNT_W >= DWELL.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_req  input  4  per-source request; bit k = source k wants the display
- i_data  input  64  packed source data; source k at [16k+15:16k]
- i_freeze  input  1  hold the current rotating source (dwell counter stalls)
- o_data  output  16  registered data of the granted source
- o_src  output  2  index of the granted source
- o_active  output  1  1 when any source is granted
- o_switch  output  1  one-cycle pulse on every change of granted source (incl. from/to idle)

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Reset values: state IDLE, o_data 0, o_src 0, o_active 0, o_switch 0, dwell counter 0, saved source 1.
- All outputs are registered. o_data is the live value of i_data[o_src], sampled with 1-cycle latency while granted. o_data = 0 in IDLE.
- States and transitions (evaluated each cycle, next state takes effect next edge):
  - IDLE:
    - i_req[0] -> PREEMPT, src 0.
    - Else any i_req[3:1] -> SHOW, lowest-index requester.
    - Else stay.
  - SHOW (src in 1..3):
    - Priority 1: i_req[0] -> PREEMPT; save current src.
    - Priority 2: i_req[src] low -> next requester round-robin after src among 1..3 (counter cleared), or IDLE if none.
    - Priority 3: counter == DWELL-1 and !i_freeze -> next requester round-robin after src. If current src is the only requester, it stays: counter clears, no o_switch.
    - Otherwise the counter increments when !i_freeze and holds when i_freeze.
  - PREEMPT (src 0):
    - Holds while i_req[0], ignoring dwell and freeze.
    - On drop: saved src if still requesting, else next round-robin after saved, else IDLE.
    - Counter is cleared on return.
- Round-robin order is 1 -> 2 -> 3 -> 1, skipping non-requesters. Source 0 is never in the rotation.
- The dwell counter is cleared on every grant change and on entry to SHOW.
- o_switch asserts in the same cycle o_src/o_active take their new values. It is not asserted on dwell expiry when the source is unchanged.
- Simultaneous requests: i_req[0] rising in the same cycle as dwell expiry -> PREEMPT wins; saved source is the pre-expiry src.
- i_freeze does not block preemption, request-drop switching, or the exit from IDLE.
- i_req is sampled synchronously; requesters are responsible for synchronising it to clk.
- Reset asserted mid-operation returns all state to reset values immediately, without waiting for a clock edge.

Test Plan (DWELL=8):
- Reset, then i_req=4'b0000 -> o_active=0, o_data=0, o_switch never pulses.
- i_req=4'b1110, data1=0x1111, data2=0x2222, data3=0x3333 -> src sequence 1,2,3,1, each held exactly 8 cycles; o_switch pulses at each change; o_data matches the granted source with 1-cycle lag.
- Only i_req[2] set for 40 cycles -> o_src stays 2, o_switch pulses once on entry only; change data2 to 0xBEEF -> o_data=0xBEEF one cycle later.
- Rotation on src 3, cycle 3 of dwell: assert i_req[0] with data0=0xDEAD for 5 cycles -> o_src=0, o_data=0xDEAD; after drop, returns to src 3 with a fresh 8-cycle dwell.
- i_freeze=1 on src 1 for 30 cycles -> src stays 1. Then drop i_req[1] -> immediate switch to next requester. With all requests dropped -> IDLE, o_active=0, o_data=0.
- Assert rst_n low asynchronously mid-PREEMPT -> outputs go to reset values before the next edge; after release with i_req=4'b0100 -> SHOW src 2.
